dds_wave_gen: RTL
=================

Name: dds_wave_gen

Overview:
- Parametrised phase-accumulator (DDS) waveform generator; successor to the single-mode LUT/counter generator in the audio waveform path.
- Four waveform modes: sine, rectangular with programmable duty, sawtooth and triangle.
- Digital amplitude scaling; config changes are glitch-free and take effect only at period boundaries.
- Streams signed samples downstream over a valid/ready handshake with full backpressure.

Parameters:
- PHASE_W, 24: phase accumulator width. Constraint: PHASE_W >= max(16, OUT_W+1).
- OUT_W, 16: sample width, signed.
- LUT_AW, 8: sine LUT address width; full-cycle table of 2^LUT_AW entries.
- AMP_W, 8: amplitude fraction bits. Unity gain = 2^AMP_W.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-low.
- en  in  1  generation enable.
- phase_clr  in  1  synchronous phase restart and pipeline flush.
- freq_word  in  PHASE_W  phase increment per produced sample.
- wave_sel  in  2  waveform select: 00 sine, 01 rect, 10 saw, 11 triangle.
- duty  in  16  rect high threshold, compared against the top 16 phase bits.
- amp  in  AMP_W+1  gain; values above 2^AMP_W saturate to 2^AMP_W.
- sample_ready  in  1  downstream accept.
- sample_valid  out  1  sample_out holds a sample.
- sample_out  out  OUT_W  signed sample.
- sample_first  out  1  this sample is the first of a period.

Behaviour:
- Reset (rst low, async):
  - phase = 0; both stage valids = 0; sample_out = 0; sample_first = 0.
  - Active config: sel = 00, duty = 0x8000, amp = 2^AMP_W.
  - Pending-first flag = 1.
- Stall and fire:
  - stall = sample_valid && !sample_ready.
  - fire = en && !stall && !phase_clr.
  - On fire, stage 1 registers wave(phase, active config) with valid = 1 and first = pending-first.
  - Also on fire: phase <= phase + freq_word (mod 2^PHASE_W).
  - On fire, pending-first <= carry-out of that add.
- Stage 2 (output):
  - When !stall, loads from stage 1: sample_out <= (s1 * amp_active) >>> AMP_W, floor rounding.
  - sample_valid and sample_first follow the stage-1 valid and first bits.
  - A stage-1 valid bit that is not refilled (no fire) clears once it is consumed.
- During stall: phase, both stages and outputs hold exactly; no sample is lost or duplicated.
- Latency: a fire in cycle N presents its sample in cycle N+2 when no stall occurs. Throughput is 1 sample/cycle.
- Config shadowing:
  - wave_sel, duty and amp are copied to the active registers when a fire produces a carry-out. The new config applies from the first sample of the next period.
  - They are also copied every cycle while en = 0.
  - They are also copied on phase_clr.
  - freq_word is not shadowed and applies on every fire.
- Waveforms, with MAX = 2^(OUT_W-1)-1 and p = phase:
  - Sine: LUT[p top LUT_AW bits]; LUT[k] = round(MAX*sin(2*pi*k/2^LUT_AW)).
  - Rect: +MAX if p top 16 bits < duty, else -MAX. duty = 0 gives a constant -MAX.
  - Saw: p top OUT_W bits with MSB inverted, i.e. a ramp from -2^(OUT_W-1) upward.
  - Triangle: u = the OUT_W phase bits below the MSB. If MSB = 0, u - 2^(OUT_W-1); else (2^OUT_W-1-u) - 2^(OUT_W-1).
- phase_clr:
  - Takes priority over fire.
  - Sets phase = 0, clears both stage valids (sample_valid = 0 next cycle, even during a stall) and sets pending-first = 1.
- freq_word = 0 produces a constant stream of wave(current phase).
- sample_first is 1 on the first sample after reset or phase_clr, and on every post-wrap sample.
- en deasserted mid-stream: no new fires. Samples already in the pipeline still drain through the handshake.

Test Plan:
- Reset release; en = 1, ready = 1, saw, freq_word = 2^20 -> first sample_valid 2 cycles after en.
  - Values -32768, -28672, ... +28672 (step 4096), 16 per period.
  - sample_first = 1 on samples 1, 17 and 33.
- Rect, duty = 0x4000, freq_word = 2^20 -> each period is 4 x +32767 then 12 x -32767.
  - duty = 0 -> all -32767.
- Backpressure: saw stream, sample_ready low for 5 cycles at sample 6.
  - sample_out and sample_valid frozen at sample 6's value.
  - After release the sequence resumes at sample 7, no gaps and no repeats.
- Mid-period switch: wave_sel saw -> sine at sample 5.
  - Saw continues to sample 16.
  - Sample 17 = 0 (sine(0)) with sample_first = 1; sample 21 = 32767.
- amp = 128 on sine at freq_word = 2^22 -> peaks +16383 / -16384.
  - amp = 0 -> all 0.
  - amp = 300 -> identical to amp = 256.
- Triangle at freq_word = 2^20 -> -32768 rising by 8192 to +32767, then falling.
  - phase_clr mid-stream -> sample_valid = 0 next cycle; restart at -32768 with sample_first = 1.
  - Async rst low mid-stall -> all outputs 0 immediately.

Source files
------------

// File: rtl/dds_wave_gen.sv
// Phase-accumulator generator (sine/rect/saw/triangle) with digital gain.
// Fire-to-output latency is 2 cycles; a stalled output freezes phase and both stages, so nothing is lost or duplicated.
module dds_wave_gen #(
  parameter int PHASE_W = 24,
  parameter int OUT_W   = 16,
  parameter int LUT_AW  = 8,
  parameter int AMP_W   = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    phase_clr,
  input  logic [PHASE_W-1:0]      freq_word,
  input  logic [1:0]              wave_sel,
  input  logic [15:0]             duty,
  input  logic [AMP_W:0]          amp,
  input  logic                    sample_ready,
  output logic                    sample_valid,
  output logic signed [OUT_W-1:0] sample_out,
  output logic                    sample_first
);
  localparam int LUT_N = 2**LUT_AW;
  localparam int PW    = OUT_W + AMP_W + 2;
  localparam logic signed [OUT_W-1:0] MAX_POS = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic signed [OUT_W-1:0] MAX_NEG = {1'b1, {(OUT_W-2){1'b0}}, 1'b1};
  localparam logic [AMP_W:0] AMP_UNITY = {1'b1, {AMP_W{1'b0}}};

  // Elaboration-time table entry: round(MAX*sin(2*pi*k/N)), Taylor series over [-pi, pi].
  function automatic int sine_entry(int k);
    real ang, term, acc, y;
    ang = 6.283185307179586 * real'(k) / real'(LUT_N);
    if (ang > 3.141592653589793) ang = ang - 6.283185307179586;
    term = ang;
    acc  = ang;
    for (int n = 1; n < 14; n++) begin
      term = -term * ang * ang / real'((2*n) * (2*n + 1));
      acc  = acc + term;
    end
    y = acc * real'((2**(OUT_W-1)) - 1);
    return (y >= 0.0) ? $rtoi(y + 0.5) : $rtoi(y - 0.5);
  endfunction

  logic signed [OUT_W-1:0] sine_lut [LUT_N];
  for (genvar k = 0; k < LUT_N; k++) begin : g_lut
    assign sine_lut[k] = OUT_W'(sine_entry(k));
  end

  logic [PHASE_W-1:0]      phase;
  logic                    pend_first;
  logic [1:0]              act_sel;
  logic [15:0]             act_duty;
  logic [AMP_W:0]          act_amp;
  logic                    s1_vld, s1_first;
  logic signed [OUT_W-1:0] s1_dat;
  logic [AMP_W:0]          s1_amp;

  logic                    stall, fire, carry;
  logic [PHASE_W:0]        phase_sum;
  logic [AMP_W:0]          amp_sat;
  logic [OUT_W-1:0]        saw_bits, tri_u, tri_t;
  logic signed [OUT_W-1:0] wave, scaled;
  logic signed [PW-1:0]    prod;

  assign stall     = sample_valid && !sample_ready;
  assign fire      = en && !stall && !phase_clr;
  assign phase_sum = {1'b0, phase} + {1'b0, freq_word};
  assign carry     = phase_sum[PHASE_W];
  assign amp_sat   = (amp > AMP_UNITY) ? AMP_UNITY : amp;

  assign saw_bits = phase[PHASE_W-1 -: OUT_W];
  assign tri_u    = phase[PHASE_W-2 -: OUT_W];
  // Second half of the triangle counts down: 2^OUT_W-1-u is just ~u.
  assign tri_t    = phase[PHASE_W-1] ? ~tri_u : tri_u;

  always_comb begin
    wave = '0;
    unique case (act_sel)
      2'b00:   wave = sine_lut[phase[PHASE_W-1 -: LUT_AW]];
      2'b01:   wave = (phase[PHASE_W-1 -: 16] < act_duty) ? MAX_POS : MAX_NEG;
      2'b10:   wave = {~saw_bits[OUT_W-1], saw_bits[OUT_W-2:0]};
      default: wave = {~tri_t[OUT_W-1], tri_t[OUT_W-2:0]};
    endcase
  end

  // Gain travels with its sample so a period-boundary amp change never touches the old period.
  assign prod   = PW'(s1_dat) * PW'($signed({1'b0, s1_amp}));
  assign scaled = OUT_W'(prod >>> AMP_W);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase        <= '0;
      pend_first   <= 1'b1;
      act_sel      <= 2'b00;
      act_duty     <= 16'h8000;
      act_amp      <= AMP_UNITY;
      s1_vld       <= 1'b0;
      s1_first     <= 1'b0;
      s1_dat       <= '0;
      s1_amp       <= AMP_UNITY;
      sample_valid <= 1'b0;
      sample_out   <= '0;
      sample_first <= 1'b0;
    end else if (phase_clr) begin
      phase        <= '0;
      pend_first   <= 1'b1;
      s1_vld       <= 1'b0;
      s1_first     <= 1'b0;
      sample_valid <= 1'b0;
      sample_first <= 1'b0;
      act_sel      <= wave_sel;
      act_duty     <= duty;
      act_amp      <= amp_sat;
    end else begin
      if (fire) begin
        s1_vld     <= 1'b1;
        s1_first   <= pend_first;
        s1_dat     <= wave;
        s1_amp     <= act_amp;
        phase      <= phase_sum[PHASE_W-1:0];
        pend_first <= carry;
      end else if (!stall) begin
        s1_vld   <= 1'b0;
        s1_first <= 1'b0;
      end
      if (!stall) begin
        sample_out   <= scaled;
        sample_valid <= s1_vld;
        sample_first <= s1_first;
      end
      if (!en || (fire && carry)) begin
        act_sel  <= wave_sel;
        act_duty <= duty;
        act_amp  <= amp_sat;
      end
    end
  end
endmodule
